data_mem_responder: RTL

Data-side memory responder for the single-cycle RISC-V core: the far end of the MemRead/MemWrite/Funct3 requests issued by the main controller. It holds the data RAM and a small memory-mapped register bank. It returns sign/zero-extended load data in the same cycle and commits byte/half/word stores on the clock edge. It also tracks access faults and a free-running cycle counter.

---
 rtl/data_mem_responder_pkg.sv | 65 ++++++
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder_data_ram_bytelane.sv | 27 ++
 rtl/data_mem_responder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants, access decode and load extension for the data-side memory responder.
// Pure declarations: no latency, no backpressure.
package data_mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MMIO_OFF_CYCLE    = 4'h0;
  localparam logic [3:0] MMIO_OFF_FAULTCNT = 4'h4;
  localparam logic [3:0] MMIO_OFF_LED      = 4'h8;
  localparam logic [3:0] MMIO_OFF_FSTAT    = 4'hC;

  localparam logic [31:0] DEFAULT_DATA_BASE = 32'h1001_0000;
  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h1002_0000;

  localparam int FS_MISALIGN = 0;
  localparam int FS_BADACC   = 1;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } acc_size_e;

  typedef struct packed {
    acc_size_e size;
    logic      unsigned_ld;
    logic      valid;
  } f3_dec_t;

  // Unsigned variants only exist for loads; as a store they are illegal.
  function automatic f3_dec_t decode_f3(input logic [2:0] f3, input logic is_store);
    f3_dec_t d;
    d = '{size: SZ_NONE, unsigned_ld: 1'b0, valid: 1'b0};
    case (f3)
      F3_B:  d = '{size: SZ_BYTE, unsigned_ld: 1'b0, valid: 1'b1};
      F3_H:  d = '{size: SZ_HALF, unsigned_ld: 1'b0, valid: 1'b1};
      F3_W:  d = '{size: SZ_WORD, unsigned_ld: 1'b0, valid: 1'b1};
      F3_BU: if (!is_store) d = '{size: SZ_BYTE, unsigned_ld: 1'b1, valid: 1'b1};
      F3_HU: if (!is_store) d = '{size: SZ_HALF, unsigned_ld: 1'b1, valid: 1'b1};
      default: d = '{size: SZ_NONE, unsigned_ld: 1'b0, valid: 1'b0};
    endcase
    return d;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] lo,
                                              input f3_dec_t d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[8*lo +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (d.size)
      SZ_BYTE: r = d.unsigned_ld ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = d.unsigned_ld ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-to-data-memory request/response bundle; master is the core, slave the responder.
// Single-cycle request, combinational load response; no backpressure.
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [1:0]  FaultStatus;
  logic [7:0]  LedOut;

  modport master (
    output MemRead, MemWrite, Funct3, Addr, WriteData,
    input  ReadData, FaultStatus, LedOut
  );

  modport slave (
    input  MemRead, MemWrite, Funct3, Addr, WriteData,
    output ReadData, FaultStatus, LedOut
  );
endinterface

// File: rtl/data_mem_responder_data_ram_bytelane.sv
// Word-organised data RAM with per-byte write enables; contents are never reset.
// Read is asynchronous (0 cycles), write commits on the rising edge; no backpressure.
module data_ram_bytelane #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Data-side responder: RAM + MMIO bank, combinational loads, edge-committed stores, fault tracking.
// Load latency 0 cycles, state updates at the next rising edge; never stalls the core.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] DATA_BASE   = DEFAULT_DATA_BASE,
  parameter logic [31:0] MMIO_BASE   = DEFAULT_MMIO_BASE
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  f3_dec_t     dec;
  logic        access;
  logic [31:0] ram_off;
  logic        ram_hit;
  logic        mmio_hit;
  logic        misaligned;
  logic        bad_acc;
  logic        fault;
  logic        acc_ok;
  logic        ram_we;
  logic        mmio_we;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] ram_rdata;
  logic [31:0] mmio_rdata;
  logic [31:0] load_word;

  logic [31:0] cycle_q, cycle_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [7:0]  led_q, led_d;
  logic [1:0]  fstat_q, fstat_d;

  // Address decode and legality; unsigned wrap of ram_off makes addresses below the base miss.
  always_comb begin
    access     = bus.MemRead | bus.MemWrite;
    dec        = decode_f3(bus.Funct3, bus.MemWrite);
    ram_off    = bus.Addr - DATA_BASE;
    ram_hit    = ram_off < RAM_BYTES;
    mmio_hit   = !ram_hit && (bus.Addr[31:4] == MMIO_BASE[31:4]);
    misaligned = ((dec.size == SZ_HALF) && bus.Addr[0]) ||
                 ((dec.size == SZ_WORD) && (bus.Addr[1:0] != 2'b00));
    bad_acc    = !dec.valid || !(ram_hit || mmio_hit) ||
                 (mmio_hit && (dec.size != SZ_WORD));
    fault      = access && (bad_acc || misaligned);
    acc_ok     = access && !fault;
    ram_we     = rst && acc_ok && bus.MemWrite && ram_hit;
    mmio_we    = acc_ok && bus.MemWrite && mmio_hit;
  end

  always_comb begin
    case (dec.size)
      SZ_BYTE: begin
        be        = 4'b0001 << bus.Addr[1:0];
        wdata_rep = {4{bus.WriteData[7:0]}};
      end
      SZ_HALF: begin
        be        = 4'b0011 << bus.Addr[1:0];
        wdata_rep = {2{bus.WriteData[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = bus.WriteData;
      end
    endcase
  end

  data_ram_bytelane #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (be),
    .addr_i  (ram_off[AW+1:2]),
    .wdata_i (wdata_rep),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    case (bus.Addr[3:0])
      MMIO_OFF_CYCLE:    mmio_rdata = cycle_q;
      MMIO_OFF_FAULTCNT: mmio_rdata = {16'h0, fcnt_q};
      MMIO_OFF_LED:      mmio_rdata = {24'h0, led_q};
      MMIO_OFF_FSTAT:    mmio_rdata = {30'h0, fstat_q};
      default:           mmio_rdata = 32'h0;
    endcase
    load_word = ram_hit ? ram_rdata : mmio_rdata;
  end

  // Read port shows pre-edge contents, so a same-cycle store never bypasses into the load.
  always_comb begin
    bus.ReadData = 32'h0;
    if (rst && bus.MemRead && acc_ok) bus.ReadData = extend_load(load_word, bus.Addr[1:0], dec);
  end

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    fcnt_d  = fcnt_q;
    if (fault && (fcnt_q != 16'hFFFF)) fcnt_d = fcnt_q + 16'd1;
    led_d = led_q;
    if (mmio_we && (bus.Addr[3:0] == MMIO_OFF_LED)) led_d = bus.WriteData[7:0];
    fstat_d = fstat_q;
    if (mmio_we && (bus.Addr[3:0] == MMIO_OFF_FSTAT)) fstat_d = 2'b00;
    // Setting is applied last so a new fault always survives a clear.
    if (fault) begin
      fstat_d[FS_MISALIGN] = fstat_d[FS_MISALIGN] | misaligned;
      fstat_d[FS_BADACC]   = fstat_d[FS_BADACC] | bad_acc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= 32'h0;
      fcnt_q  <= 16'h0;
      led_q   <= 8'h0;
      fstat_q <= 2'b00;
    end else begin
      cycle_q <= cycle_d;
      fcnt_q  <= fcnt_d;
      led_q   <= led_d;
      fstat_q <= fstat_d;
    end
  end

  assign bus.FaultStatus = fstat_q;
  assign bus.LedOut      = led_q;

endmodule
